// File: rtl/board_io_cond.sv
// Board I/O conditioning: SoC reset sequencer, input synchronise/debounce, edge pulses.
// Optional edge interrupt enabled by defining BOARD_IO_EDGE_IRQ_EN.
module board_io_cond #(
  parameter int NUM_IN       = 16,
  parameter int TICK_DIV     = 100000,
  parameter int STABLE_TICKS = 10,
  parameter int RST_HOLD     = 16,
  parameter bit INIT_LEVEL   = 1'b0
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              pll_locked_i,
  input  logic [NUM_IN-1:0] raw_i,
  input  logic [NUM_IN-1:0] irq_clr_i,
  output logic              sys_rst_o,
  output logic [NUM_IN-1:0] level_o,
  output logic [NUM_IN-1:0] rise_o,
  output logic [NUM_IN-1:0] fall_o,
  output logic              irq_o
);

  localparam int HOLD_W = $clog2(RST_HOLD + 1);
  localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CNT_W  = $clog2(STABLE_TICKS + 1);

  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(RST_HOLD);
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_TICKS - 1);

  // ---------------------------------------------------------------------------
  // Reset sequencer
  // ---------------------------------------------------------------------------
  logic              lock_meta;
  logic              lock_s;
  logic [HOLD_W-1:0] hold_cnt;

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
      hold_cnt  <= '0;
      sys_rst_o <= 1'b1;
    end else begin
      lock_meta <= pll_locked_i;
      lock_s    <= lock_meta;
      if (!lock_s) begin
        hold_cnt  <= '0;
        sys_rst_o <= 1'b1;
      end else if (hold_cnt != HOLD_MAX) begin
        hold_cnt <= hold_cnt + 1'b1;
        if (hold_cnt == HOLD_MAX - 1'b1) sys_rst_o <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Shared debounce sample prescaler
  // ---------------------------------------------------------------------------
  logic [PRE_W-1:0] pre_cnt;
  logic             tick;

  assign tick = (pre_cnt == PRE_LAST);

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i)  pre_cnt <= '0;
    else if (tick)  pre_cnt <= '0;
    else            pre_cnt <= pre_cnt + 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Input synchroniser and per-channel debounce
  // ---------------------------------------------------------------------------
  logic [NUM_IN-1:0] raw_meta;
  logic [NUM_IN-1:0] raw_s;
  logic [CNT_W-1:0]  cnt [NUM_IN];

  // Synchroniser resets to the idle level so release never looks like an edge.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      raw_meta <= {NUM_IN{INIT_LEVEL}};
      raw_s    <= {NUM_IN{INIT_LEVEL}};
    end else begin
      raw_meta <= raw_i;
      raw_s    <= raw_meta;
    end
  end

  // NOTE: the counter array is small and must start from zero after every
  // reset, so it is reset element by element rather than left as RAM.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      for (int i = 0; i < NUM_IN; i++) cnt[i] <= '0;
      level_o <= {NUM_IN{INIT_LEVEL}};
      rise_o  <= '0;
      fall_o  <= '0;
    end else begin
      rise_o <= '0;
      fall_o <= '0;
      for (int i = 0; i < NUM_IN; i++) begin
        if (raw_s[i] == level_o[i]) begin
          cnt[i] <= '0;
        end else if (tick) begin
          if (cnt[i] == CNT_LAST) begin
            cnt[i]     <= '0;
            level_o[i] <= raw_s[i];
            rise_o[i]  <= raw_s[i];
            fall_o[i]  <= ~raw_s[i];
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Edge interrupt
  // ---------------------------------------------------------------------------
`ifdef BOARD_IO_EDGE_IRQ_EN
  logic [NUM_IN-1:0] pending;

  // A new edge in the same cycle as its clear keeps the flag set.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) pending <= '0;
    else           pending <= (pending & ~irq_clr_i) | rise_o | fall_o;
  end

  assign irq_o = |pending;
`else
  logic unused_irq_clr;

  assign unused_irq_clr = ^irq_clr_i;
  assign irq_o          = 1'b0;
`endif

endmodule
